// File: rtl/battle_sequencer_if.sv
// Signal bundle between the battle sequencer and its surroundings.
// Clock and reset are kept as plain ports on the sequencer itself.
//   master : drives the player controls (on_off, status, pulses, placement, target)
//   slave  : the sequencer; drives display pattern, counters, flags and state
// ship_in / disp bit index = col*7 + row.
interface battle_sequencer_if;
    logic        on_off;
    logic        status;
    logic        save_pulse;
    logic        attack_pulse;
    logic [34:0] ship_in;
    logic [2:0]  columns_attack;
    logic [2:0]  rows_attack;
    logic [34:0] disp;
    logic [5:0]  shots_left;
    logic [5:0]  hits_left;
    logic        last_hit;
    logic        game_over;
    logic        win;
    logic [2:0]  state;

    modport master (
        output on_off, status, save_pulse, attack_pulse, ship_in, columns_attack, rows_attack,
        input  disp, shots_left, hits_left, last_hit, game_over, win, state
    );

    modport slave (
        input  on_off, status, save_pulse, attack_pulse, ship_in, columns_attack, rows_attack,
        output disp, shots_left, hits_left, last_hit, game_over, win, state
    );
endinterface

// File: rtl/battle_sequencer.sv
// Battleship game sequencer: ship placement, shot handling, result flash and end of game.
// Ports:
//   clock : system clock (381 Hz divided clock)
//   reset : asynchronous active-low reset
//   bus   : battle_sequencer_if.slave (controls in; disp, shots_left, hits_left,
//           last_hit, game_over, win, state out)
// Parameters: MAX_SHOTS (shots per game), FLASH_CYCLES (result dwell), BLINK_DIV
// (half-period of the miss-cell blink).
// Configuration macro: SHOT_LIMIT_EN -- when defined, running out of shots ends the game;
// when undefined, shots_left stays at MAX_SHOTS and only sinking every ship ends it.
module battle_sequencer #(
    parameter int unsigned MAX_SHOTS    = 15,
    parameter int unsigned FLASH_CYCLES = 381,
    parameter int unsigned BLINK_DIV    = 190
) (
    input logic            clock,
    input logic            reset,
    battle_sequencer_if.slave bus
);

    localparam int unsigned FlashW = $clog2(FLASH_CYCLES + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [5:0]        ShotsInit = 6'(MAX_SHOTS);

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StPlace  = 3'd1,
        StArmed  = 3'd2,
        StAttack = 3'd3,
        StResult = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e            state_q;
    logic [34:0]       ship_q;
    logic [34:0]       shot_q;
    logic [5:0]        shots_q;
    logic [5:0]        hits_q;
    logic              last_hit_q;
    logic              game_over_q;
    logic              win_q;
    logic [5:0]        tgt_q;
    logic [FlashW-1:0] flash_q;
    logic [BlinkW-1:0] blink_cnt_q;
    logic              blink_q;

    logic [5:0]        tgt_idx;
    logic              tgt_valid;
    logic              tgt_fresh;
    logic [5:0]        ship_pop;
    logic [34:0]       disp_c;

    // Max 7*7+7 = 56, fits in 6 bits; out-of-range targets are gated by tgt_valid.
    assign tgt_idx   = 6'(bus.columns_attack) * 6'd7 + 6'(bus.rows_attack);
    assign tgt_valid = (bus.columns_attack < 3'd5) && (bus.rows_attack < 3'd7);
    assign tgt_fresh = tgt_valid && !shot_q[tgt_idx];

    always_comb begin
        ship_pop = '0;
        for (int i = 0; i < 35; i++) begin
            ship_pop = ship_pop + 6'(bus.ship_in[i]);
        end
    end

    always_comb begin
        disp_c = '0;
        unique case (state_q)
            StOff:    disp_c = '0;
            StPlace:  disp_c = bus.ship_in;
            StArmed:  disp_c = ship_q;
            StAttack,
            StDone:   disp_c = (shot_q & ship_q) | (shot_q & ~ship_q & {35{blink_q}});
            StResult: begin
                // Only the target cell: steady on a hit, blinking on a miss.
                for (int i = 0; i < 35; i++) begin
                    disp_c[i] = (tgt_q == 6'(i)) && (last_hit_q || blink_q);
                end
            end
            default:  disp_c = '0;
        endcase
    end

    assign bus.disp       = disp_c;
    assign bus.shots_left = shots_q;
    assign bus.hits_left  = hits_q;
    assign bus.last_hit   = last_hit_q;
    assign bus.game_over  = game_over_q;
    assign bus.win        = win_q;
    assign bus.state      = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StOff;
            ship_q      <= '0;
            shot_q      <= '0;
            shots_q     <= '0;
            hits_q      <= '0;
            last_hit_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            tgt_q       <= '0;
            flash_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (!bus.on_off) begin
            state_q     <= StOff;
            ship_q      <= '0;
            shot_q      <= '0;
            shots_q     <= '0;
            hits_q      <= '0;
            last_hit_q  <= 1'b0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            tgt_q       <= '0;
            flash_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end

            unique case (state_q)
                StOff: begin
                    state_q <= StPlace;
                end
                StPlace: begin
                    // An empty fleet would end the game instantly, so it is refused.
                    if (bus.save_pulse && (bus.ship_in != '0)) begin
                        ship_q  <= bus.ship_in;
                        hits_q  <= ship_pop;
                        shots_q <= ShotsInit;
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (bus.status) begin
                        state_q <= StAttack;
                    end
                end
                StAttack: begin
                    if (bus.attack_pulse && tgt_fresh) begin
                        shot_q[tgt_idx] <= 1'b1;
                        tgt_q           <= tgt_idx;
                        last_hit_q      <= ship_q[tgt_idx];
                        if (ship_q[tgt_idx] && (hits_q != '0)) begin
                            hits_q <= hits_q - 6'd1;
                        end
`ifdef SHOT_LIMIT_EN
                        if (shots_q != '0) begin
                            shots_q <= shots_q - 6'd1;
                        end
`endif
                        flash_q <= FlashLoad;
                        state_q <= StResult;
                    end
                end
                StResult: begin
                    if (flash_q == '0) begin
                        if (hits_q == '0) begin
                            state_q     <= StDone;
                            game_over_q <= 1'b1;
                            win_q       <= 1'b1;
                        end
`ifdef SHOT_LIMIT_EN
                        else if (shots_q == '0) begin
                            state_q     <= StDone;
                            game_over_q <= 1'b1;
                            win_q       <= 1'b0;
                        end
`endif
                        else begin
                            state_q <= StAttack;
                        end
                    end else begin
                        flash_q <= flash_q - 1'b1;
                    end
                end
                StDone: begin
                    if (bus.save_pulse) begin
                        shot_q      <= '0;
                        last_hit_q  <= 1'b0;
                        game_over_q <= 1'b0;
                        win_q       <= 1'b0;
                        state_q     <= StPlace;
                    end
                end
                default: begin
                    state_q <= StOff;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_sequencer.sv
module tb_battle_sequencer;

    localparam int unsigned FLASH = 381;
    localparam int unsigned BLINK = 190;

    logic clock;
    logic reset;
    battle_sequencer_if bus ();

    battle_sequencer #(
        .MAX_SHOTS   (15),
        .FLASH_CYCLES(FLASH),
        .BLINK_DIV   (BLINK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        on_off;
        logic        status;
        logic        save;
        logic        attack;
        logic [34:0] ship;
        logic [2:0]  col;
        logic [2:0]  row;
        logic        wait_res;
        logic [2:0]  e_state;
        logic [5:0]  e_shots;
        logic [5:0]  e_hits;
        logic        e_last;
        logic        e_over;
        logic        e_win;
        logic [34:0] e_disp;
    } vec_t;

    vec_t vecs[17];

    // Expected shots_left after n remaining shots; constant when the limit is compiled out.
    function automatic logic [5:0] sh(input int n);
`ifdef SHOT_LIMIT_EN
        return 6'(n);
`else
        return 6'(n - n + 15);
`endif
    endfunction

    function automatic vec_t mk(input logic on, input logic st, input logic sv, input logic at,
                                input logic [34:0] ship, input logic [2:0] col,
                                input logic [2:0] row, input logic wr, input logic [2:0] es,
                                input logic [5:0] esh, input logic [5:0] eh, input logic el,
                                input logic eo, input logic ew, input logic [34:0] ed);
        vec_t v;
        v.on_off = on;  v.status = st;  v.save = sv;  v.attack = at;
        v.ship = ship;  v.col = col;    v.row = row;  v.wait_res = wr;
        v.e_state = es; v.e_shots = esh; v.e_hits = eh;
        v.e_last = el;  v.e_over = eo;  v.e_win = ew; v.e_disp = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic ok, input string detail);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: %s", nm, detail);
    endtask

    task automatic check_all(input string nm, input logic [2:0] es, input logic [5:0] esh,
                             input logic [5:0] eh, input logic el, input logic eo,
                             input logic ew, input logic [34:0] ed, input logic cd);
        logic ok;
        ok = (bus.state === es) && (bus.shots_left === esh) && (bus.hits_left === eh) &&
             (bus.last_hit === el) && (bus.game_over === eo) && (bus.win === ew) &&
             (!cd || (bus.disp === ed));
        check(nm, ok, $sformatf(
            "got state=%0d shots=%0d hits=%0d last=%b over=%b win=%b disp=%h; need state=%0d shots=%0d hits=%0d last=%b over=%b win=%b disp=%h(chk=%b)",
            bus.state, bus.shots_left, bus.hits_left, bus.last_hit, bus.game_over, bus.win,
            bus.disp, es, esh, eh, el, eo, ew, ed, cd));
    endtask

    // Entered while already in the first RESULT cycle.
    task automatic wait_result(input string nm, input logic hit, input logic [34:0] tgt);
        int n;
        int guard;
        logic bad, seen_on, seen_off;
        n = 1; guard = 0; bad = 1'b0; seen_on = 1'b0; seen_off = 1'b0;
        while (bus.state === 3'd4 && guard < 2 * FLASH) begin
            if ((bus.disp & ~tgt) != '0) bad = 1'b1;
            if (bus.disp === tgt) seen_on = 1'b1;
            else seen_off = 1'b1;
            step();
            guard++;
            if (bus.state === 3'd4) n++;
        end
        check({nm, "_dwell"}, n == FLASH,
              $sformatf("result lasted %0d cycles, need %0d", n, FLASH));
        check({nm, "_flash"}, !bad && seen_on && (hit ? !seen_off : seen_off),
              $sformatf("stray=%b on=%b off=%b, need stray=0 on=1 off=%b", bad, seen_on,
                        seen_off, !hit));
    endtask

    task automatic fire(input int idx);
        bus.columns_attack = 3'(idx / 7);
        bus.rows_attack    = 3'(idx % 7);
        bus.attack_pulse   = 1'b1;
        step();
        bus.attack_pulse   = 1'b0;
    endtask

    initial begin
        logic [34:0] miss_mask;
        logic        ok, seen_on, seen_off;

        bus.on_off = 1'b0; bus.status = 1'b0; bus.save_pulse = 1'b0; bus.attack_pulse = 1'b0;
        bus.ship_in = '0; bus.columns_attack = '0; bus.rows_attack = '0;
        reset = 1'b0;

        //            on st sv at ship      c  r  wr  st   shots   hits last ovr win disp
        vecs[0]  = mk(1, 0, 0, 0, 35'h7,    0, 0, 0, 3'd1, 6'd0,   6'd0, 0, 0, 0, 35'h7);
        vecs[1]  = mk(1, 0, 1, 0, 35'h0,    0, 0, 0, 3'd1, 6'd0,   6'd0, 0, 0, 0, 35'h0);
        vecs[2]  = mk(1, 0, 1, 0, 35'h7,    0, 0, 0, 3'd2, 6'd15,  6'd3, 0, 0, 0, 35'h7);
        vecs[3]  = mk(1, 1, 0, 0, 35'h7,    0, 0, 0, 3'd3, 6'd15,  6'd3, 0, 0, 0, 35'h0);
        vecs[4]  = mk(1, 1, 0, 1, 35'h7,    0, 1, 1, 3'd4, sh(14), 6'd2, 1, 0, 0, 35'h2);
        vecs[5]  = mk(1, 0, 0, 0, 35'h7,    0, 1, 0, 3'd3, sh(14), 6'd2, 1, 0, 0, 35'h2);
        vecs[6]  = mk(1, 1, 0, 1, 35'h7,    0, 1, 0, 3'd3, sh(14), 6'd2, 1, 0, 0, 35'h2);
        vecs[7]  = mk(1, 1, 0, 1, 35'h7,    5, 0, 0, 3'd3, sh(14), 6'd2, 1, 0, 0, 35'h2);
        vecs[8]  = mk(1, 1, 0, 1, 35'h7,    0, 7, 0, 3'd3, sh(14), 6'd2, 1, 0, 0, 35'h2);
        vecs[9]  = mk(1, 1, 1, 1, 35'h7,    0, 0, 1, 3'd4, sh(13), 6'd1, 1, 0, 0, 35'h1);
        vecs[10] = mk(1, 1, 0, 0, 35'h7,    0, 0, 0, 3'd3, sh(13), 6'd1, 1, 0, 0, 35'h3);
        vecs[11] = mk(1, 1, 0, 1, 35'h7,    0, 2, 1, 3'd4, sh(12), 6'd0, 1, 0, 0, 35'h4);
        vecs[12] = mk(1, 1, 0, 0, 35'h7,    0, 2, 0, 3'd5, sh(12), 6'd0, 1, 1, 1, 35'h7);
        vecs[13] = mk(1, 1, 0, 1, 35'h7,    0, 0, 0, 3'd5, sh(12), 6'd0, 1, 1, 1, 35'h7);
        vecs[14] = mk(1, 1, 1, 1, 35'h7,    0, 0, 0, 3'd1, sh(12), 6'd0, 0, 0, 0, 35'h7);
        vecs[15] = mk(1, 1, 1, 0, 35'h7,    0, 0, 0, 3'd2, 6'd15,  6'd3, 0, 0, 0, 35'h7);
        vecs[16] = mk(1, 1, 0, 0, 35'h7,    0, 0, 0, 3'd3, 6'd15,  6'd3, 0, 0, 0, 35'h0);

        step();
        check_all("reset_state", 3'd0, 6'd0, 6'd0, 0, 0, 0, 35'h0, 1);
        reset = 1'b1;
        step();
        check_all("off_hold", 3'd0, 6'd0, 6'd0, 0, 0, 0, 35'h0, 1);

        for (int i = 0; i < 17; i++) begin
            bus.on_off = vecs[i].on_off;
            bus.status = vecs[i].status;
            bus.save_pulse = vecs[i].save;
            bus.attack_pulse = vecs[i].attack;
            bus.ship_in = vecs[i].ship;
            bus.columns_attack = vecs[i].col;
            bus.rows_attack = vecs[i].row;
            step();
            bus.save_pulse = 1'b0;
            bus.attack_pulse = 1'b0;
            check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_shots, vecs[i].e_hits,
                      vecs[i].e_last, vecs[i].e_over, vecs[i].e_win, vecs[i].e_disp, 1);
            if (vecs[i].wait_res) wait_result($sformatf("vec%0d", i), 1'b1, vecs[i].e_disp);
            if (i == 12) begin
                // Win display: hit cells stay lit across several blink periods.
                ok = 1'b1;
                for (int c = 0; c < 2 * BLINK + 4; c++) begin
                    if (bus.disp !== 35'h7 || bus.state !== 3'd5) ok = 1'b0;
                    step();
                end
                check("done_steady", ok, $sformatf("disp=%h state=%0d, need 7 steady in DONE",
                                                   bus.disp, bus.state));
            end
        end

        // Fifteen misses on cells 3..17.
        for (int k = 0; k < 15; k++) begin
            fire(3 + k);
            check_all($sformatf("miss%0d", k), 3'd4, sh(14 - k), 6'd3, 0, 0, 0, 35'h0, 0);
            wait_result($sformatf("miss%0d", k), 1'b0, 35'h1 << (3 + k));
        end
`ifdef SHOT_LIMIT_EN
        check_all("out_of_shots", 3'd5, 6'd0, 6'd3, 0, 1, 0, 35'h0, 0);
`else
        check_all("no_limit", 3'd3, 6'd15, 6'd3, 0, 0, 0, 35'h0, 0);
`endif

        miss_mask = 35'h3FFF8;
        ok = 1'b1; seen_on = 1'b0; seen_off = 1'b0;
        for (int c = 0; c < 2 * BLINK + 4; c++) begin
            if (bus.disp === miss_mask) seen_on = 1'b1;
            else if (bus.disp === 35'h0) seen_off = 1'b1;
            else ok = 1'b0;
            step();
        end
        check("miss_blink", ok && seen_on && seen_off,
              $sformatf("clean=%b on=%b off=%b, need 1 1 1", ok, seen_on, seen_off));

        bus.on_off = 1'b0;
        step();
        check_all("power_off", 3'd0, 6'd0, 6'd0, 0, 0, 0, 35'h0, 1);

        // Power drop in the middle of a result flash.
        bus.on_off = 1'b1;
        step();
        bus.save_pulse = 1'b1;
        step();
        bus.save_pulse = 1'b0;
        step();
        fire(24);
        check_all("mid_fire", 3'd4, sh(14), 6'd3, 0, 0, 0, 35'h0, 0);
        for (int c = 0; c < 5; c++) step();
        bus.on_off = 1'b0;
        step();
        check_all("off_mid_result", 3'd0, 6'd0, 6'd0, 0, 0, 0, 35'h0, 1);

        // Asynchronous reset while in ATTACK.
        bus.on_off = 1'b1;
        step();
        bus.save_pulse = 1'b1;
        step();
        bus.save_pulse = 1'b0;
        step();
        fire(0);
        wait_result("pre_reset", 1'b1, 35'h1);
        check_all("pre_reset", 3'd3, sh(14), 6'd2, 1, 0, 0, 35'h1, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 3'd0, 6'd0, 6'd0, 0, 0, 0, 35'h0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
